mnist_lut_net_scheduler: RTL

//  Shares one LUT-MLP inference pipeline (user/data/valid in, user/data/valid out, cke-stalled, fixed latency)

---
 rtl/mnist_lut_pkg.sv | 18 +
 rtl/mnist_rr_arbiter.sv | 38 +++
 rtl/mnist_lut_net_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mnist_lut_pkg.sv
// Shared widths and tag layout for the LUT-MLP net and its scheduler.
// The net user field is {id, last, user} with user in the low bits.
package mnist_lut_pkg;
   localparam int USER_WIDTH   = 8;
   localparam int DATA_WIDTH   = 784;
   localparam int CLASS_NUM    = 10;
   localparam int CHANNEL_NUM  = 8;
   localparam int OUT_WIDTH    = CLASS_NUM * CHANNEL_NUM;
   localparam int TAG_USER_LSB = 0;

   function automatic int tag_last_bit(input int user_w);
      return user_w;
   endfunction

   function automatic int tag_id_lsb(input int user_w);
      return user_w + 1;
   endfunction
endpackage

// File: rtl/mnist_rr_arbiter.sv
// Round-robin pick of the first asserted request at or after i_rr_ptr.
// Purely combinational; all outputs are zero when i_en is low.
module mnist_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_en,
   input  logic [IDX_W-1:0]   i_rr_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);
   logic [2*NUM_REQ-1:0] w_dbl;
   logic [IDX_W:0]       w_sum;

   // Rotating the doubled vector puts the pointer position at bit 0.
   assign w_dbl = {i_req, i_req} >> i_rr_ptr;

   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_sum   = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (i_en && w_dbl[j]) begin
            w_sum   = {1'b0, i_rr_ptr} + (IDX_W+1)'(j);
            o_valid = 1'b1;
            o_idx   = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                                                     : IDX_W'(w_sum);
         end
      end
   end

   always_comb begin
      o_grant = '0;
      if (o_valid) o_grant[o_idx] = 1'b1;
   end
endmodule

// File: rtl/mnist_lut_net_scheduler.sv
// Shares one cke-stalled, fixed-latency LUT-MLP net between NUM_REQ frame sources;
// results are routed back by the requester tag carried in the net user field.
module mnist_lut_net_scheduler #(
   parameter int NUM_REQ      = 2,
   parameter int ID_WIDTH     = 1,
   parameter int USER_WIDTH   = mnist_lut_pkg::USER_WIDTH,
   parameter int DATA_WIDTH   = mnist_lut_pkg::DATA_WIDTH,
   parameter int OUT_WIDTH    = mnist_lut_pkg::OUT_WIDTH,
   parameter int MAX_INFLIGHT = 64
)(
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             cke,
   input  logic [NUM_REQ-1:0]               s_last,
   input  logic [NUM_REQ*USER_WIDTH-1:0]    s_user,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_data,
   input  logic [NUM_REQ-1:0]               s_valid,
   output logic [NUM_REQ-1:0]               s_ready,
   output logic                             net_cke,
   output logic [ID_WIDTH+USER_WIDTH:0]     net_in_user,
   output logic [DATA_WIDTH-1:0]            net_in_data,
   output logic                             net_in_valid,
   input  logic [ID_WIDTH+USER_WIDTH:0]     net_out_user,
   input  logic [OUT_WIDTH-1:0]             net_out_data,
   input  logic                             net_out_valid,
   output logic                             m_last,
   output logic [USER_WIDTH-1:0]            m_user,
   output logic [OUT_WIDTH-1:0]             m_data,
   output logic [NUM_REQ-1:0]               m_valid,
   input  logic [NUM_REQ-1:0]               m_ready,
   output logic                             busy,
   output logic                             err_bad_id
);
   import mnist_lut_pkg::*;

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TAG_W  = ID_WIDTH + 1 + USER_WIDTH;
   localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
   localparam int ID_LSB = tag_id_lsb(USER_WIDTH);
   localparam int LAST_B = tag_last_bit(USER_WIDTH);

   logic [IDX_W-1:0]      r_rr_ptr;
   logic [CNT_W-1:0]      r_inflight;
   logic                  r_in_valid;
   logic [TAG_W-1:0]      r_in_user;
   logic [DATA_WIDTH-1:0] r_in_data;
   logic                  r_err_bad_id;

   logic [ID_WIDTH-1:0]   w_out_id;
   logic [NUM_REQ-1:0]    w_hit;
   logic [NUM_REQ-1:0]    w_grant;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_id_ok;
   logic                  w_stall;
   logic                  w_net_cke;
   logic                  w_retire;
   logic                  w_room;
   logic                  w_arb_en;
   logic                  w_acc;

   assign w_out_id = net_out_user[ID_LSB +: ID_WIDTH];
   assign w_id_ok  = 32'(w_out_id) < 32'(NUM_REQ);

   always_comb begin
      w_hit = '0;
      for (int r = 0; r < NUM_REQ; r++)
         w_hit[r] = net_out_valid && (32'(w_out_id) == 32'(r));
   end

   // A result whose owner is not ready freezes the whole net; bad tags never stall.
   assign w_stall   = |(w_hit & ~m_ready);
   assign w_net_cke = cke & ~w_stall;
   assign w_retire  = w_net_cke & net_out_valid;
   assign w_room    = (r_inflight < CNT_W'(MAX_INFLIGHT)) | w_retire;
   assign w_arb_en  = reset_n & w_net_cke & w_room;

   mnist_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .i_req    (s_valid),
      .i_en     (w_arb_en),
      .i_rr_ptr (r_rr_ptr),
      .o_grant  (w_grant),
      .o_idx    (w_idx),
      .o_valid  (w_acc)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rr_ptr     <= '0;
         r_inflight   <= '0;
         r_in_valid   <= 1'b0;
         r_in_user    <= '0;
         r_in_data    <= '0;
         r_err_bad_id <= 1'b0;
      end else if (w_net_cke) begin
         r_in_valid <= w_acc;
         if (w_acc) begin
            r_in_user <= {ID_WIDTH'(w_idx), s_last[w_idx], s_user[w_idx*USER_WIDTH +: USER_WIDTH]};
            r_in_data <= s_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
            r_rr_ptr  <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
         end
         case ({w_acc, w_retire})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - 1'b1;
            default: ;
         endcase
         if (w_retire && !w_id_ok) r_err_bad_id <= 1'b1;
      end
   end

   assign s_ready      = w_grant;
   assign net_cke      = w_net_cke;
   assign net_in_valid = r_in_valid;
   assign net_in_user  = r_in_user;
   assign net_in_data  = r_in_data;
   assign m_valid      = cke ? w_hit : '0;
   assign m_last       = net_out_user[LAST_B];
   assign m_user       = net_out_user[TAG_USER_LSB +: USER_WIDTH];
   assign m_data       = net_out_data;
   assign busy         = (r_inflight != '0) | r_in_valid;
   assign err_bad_id   = r_err_bad_id;
endmodule
